// File: rtl/io_uart.sv
// Memory-mapped UART: DATA/STATUS registers on a CPU bus, TX with a one-byte
// holding register, RX with a 2-flop synchronizer and mid-bit sampling.
module io_uart #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_sel,
  input  logic [15:0] address,
  input  logic        rw,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        rxd,
  output logic        txd,
  output logic        irq_n,
  output logic [3:0]  dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          tx_state_q, tx_state_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic [7:0]      tx_hold_q, tx_hold_d;
  logic            tx_empty_q, tx_empty_d;
  logic            txd_q, txd_d;

  logic            rx_s1_q, rx_s1_d;
  logic            rx_s2_q, rx_s2_d;
  logic            rx_prev_q, rx_prev_d;
  state_t          rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_full_q, rx_full_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic            rd_data, wr_data, wr_stat;
  logic [7:0]      status;
  logic            unused_addr;

  // Bus handshake: one access per cycle with io_sel low; rw selects direction.
  assign rd_data     = ~io_sel &  rw & ~address[0];
  assign wr_data     = ~io_sel & ~rw & ~address[0];
  assign wr_stat     = ~io_sel & ~rw &  address[0];
  assign unused_addr = ^address[15:1];

  assign status    = {4'b0000, frame_err_q, overrun_q, tx_empty_q, rx_full_q};
  assign txd       = txd_q;
  assign irq_n     = ~(rx_full_q | overrun_q | frame_err_q);
  assign dbg_state = {tx_state_q, rx_state_q};

  always_comb begin
    data_out = 8'h00;
    if (!io_sel && rw) data_out = address[0] ? status : rx_data_q;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_empty_d = tx_empty_q;
    txd_d      = txd_q;

    if (wr_data && tx_empty_q) begin
      tx_hold_d  = data_in;
      tx_empty_d = 1'b0;
    end

    case (tx_state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty_q) begin
          tx_shift_d = tx_hold_q;
          tx_empty_d = 1'b1;
          tx_state_d = S_START;
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          // A refilled holding register starts the next frame with no idle bit.
          if (!tx_empty_q) begin
            tx_shift_d = tx_hold_q;
            tx_empty_d = 1'b1;
            tx_state_d = S_START;
            txd_d      = 1'b0;
          end else begin
            tx_state_d = S_IDLE;
            txd_d      = 1'b1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = S_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  always_comb begin
    rx_s1_d     = rxd;
    rx_s2_d     = rx_s1_q;
    rx_prev_d   = rx_s2_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_full_d   = rx_full_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    if (rd_data) rx_full_d = 1'b0;
    if (wr_stat) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    case (rx_state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = '0;
        end
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_IDLE;
          // A DATA read on the completion edge frees the register for the new byte.
          if (rx_s2_q) begin
            if (!rx_full_q || rd_data) begin
              rx_data_d = rx_shift_q;
              rx_full_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_hold_q   <= 8'h00;
      tx_empty_q  <= 1'b1;
      txd_q       <= 1'b1;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= S_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_full_q   <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      tx_empty_q  <= tx_empty_d;
      txd_q       <= txd_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_full_q   <= rx_full_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart: register vectors from a table, a TX frame monitor fed by
// an expected-byte queue, and hand-written RX/reset sequences.
module tb_io_uart;

  localparam int CPB = 16;

  logic        clk;
  logic        reset_n;
  logic        io_sel;
  logic [15:0] address;
  logic        rw;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        rxd;
  logic        txd;
  logic        irq_n;
  logic [3:0]  dbg_state;

  io_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .io_sel    (io_sel),
    .address   (address),
    .rw        (rw),
    .data_in   (data_in),
    .data_out  (data_out),
    .rxd       (rxd),
    .txd       (txd),
    .irq_n     (irq_n),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int frames_done = 0;
  int idle_cnt = 0;
  int gaps[16];

  typedef struct {
    logic        sel_n;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [7:0]  exp_dout;
    logic        exp_irq_n;
  } vec_t;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // driver tasks: all start and end on a falling clock edge
  task automatic bus_write(input logic a0, input logic [7:0] d);
    io_sel  = 1'b0;
    rw      = 1'b0;
    address = {15'h6800, a0};
    data_in = d;
    @(negedge clk);
    io_sel  = 1'b1;
    rw      = 1'b1;
    data_in = 8'h00;
  endtask

  task automatic bus_read(input logic a0, output logic [7:0] d);
    io_sel  = 1'b0;
    rw      = 1'b1;
    address = {15'h6800, a0};
    #1 d = data_out;
    @(negedge clk);
    io_sel = 1'b1;
  endtask

  task automatic status_check(input string name, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(1'b1, d);
    check8(name, d, exp);
  endtask

  task automatic read_data_check(input string name);
    logic [7:0] d;
    bus_read(1'b0, d);
    if (rx_exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %h, expected no pending byte", name, d);
    end else begin
      check8(name, d, rx_exp_q.pop_front());
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_int("tx_frames_seen", frames_done, n);
  endtask

  // scoreboard: every transmitted frame is checked cycle by cycle against tx_exp_q
  initial begin : tx_monitor
    logic [9:0] frame;
    int bad;
    bit aborted;
    int gap;
    forever begin
      @(negedge clk);
      if (reset_n && txd === 1'b0) begin
        gap = idle_cnt;
        if (tx_exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_unexpected_frame: start bit seen, expected idle line");
          repeat (10 * CPB - 1) @(negedge clk);
        end else begin
          frame   = {1'b1, tx_exp_q.pop_front(), 1'b0};
          bad     = 0;
          aborted = 1'b0;
          for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (!reset_n) aborted = 1'b1;
              if (!aborted && txd !== frame[b]) bad++;
            end
          end
          if (!aborted) begin
            check_int($sformatf("tx_frame_%h_bad_cycles", frame[8:1]), bad, 0);
            if (frames_done < 16) gaps[frames_done] = gap;
            frames_done++;
          end
        end
        idle_cnt = 0;
      end else if (txd === 1'b1) begin
        idle_cnt++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t vecs[9];
    logic [7:0] d;

    vecs[0] = '{1'b1, 1'b1, 16'hD001, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 16'hD001, 8'h00, 8'h02, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 16'hD000, 8'h00, 8'h00, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 16'hD001, 8'hFF, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 16'hFFF1, 8'h00, 8'h02, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 16'hD000, 8'h55, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 16'h0001, 8'h00, 8'h02, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 16'hD002, 8'h00, 8'h00, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 16'hD000, 8'h00, 8'h00, 1'b1};

    reset_n = 1'b0;
    io_sel  = 1'b1;
    rw      = 1'b1;
    address = 16'h0000;
    data_in = 8'h00;
    rxd     = 1'b1;

    repeat (3) @(negedge clk);
    io_sel  = 1'b0;
    address = 16'hD001;
    #1;
    check8("reset_status", data_out, 8'h02);
    check8("reset_txd", {7'h00, txd}, 8'h01);
    check8("reset_irq_n", {7'h00, irq_n}, 8'h01);
    check8("reset_fsm_state", {4'h0, dbg_state}, 8'h00);
    io_sel = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // register access vectors
    for (int i = 0; i < 9; i++) begin
      io_sel  = vecs[i].sel_n;
      rw      = vecs[i].rw;
      address = vecs[i].addr;
      data_in = vecs[i].din;
      #1;
      check8($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_dout);
      check8($sformatf("vec%0d_irq_n", i), {7'h00, irq_n}, {7'h00, vecs[i].exp_irq_n});
      @(negedge clk);
    end
    io_sel  = 1'b1;
    rw      = 1'b1;
    data_in = 8'h00;

    // single TX frame
    tx_exp_q.push_back(8'hA5);
    bus_write(1'b0, 8'hA5);
    status_check("tx_hold_full_after_write", 8'h00);
    status_check("tx_empty_one_cycle_later", 8'h02);
    wait_frames(1, 400);

    // back-to-back frames; third write lands on a full holding register
    tx_exp_q.push_back(8'h01);
    bus_write(1'b0, 8'h01);
    repeat (20) @(negedge clk);
    tx_exp_q.push_back(8'h02);
    bus_write(1'b0, 8'h02);
    status_check("tx_hold_full_second", 8'h00);
    bus_write(1'b0, 8'h03);
    wait_frames(3, 800);
    check_int("tx_back_to_back_gap", gaps[2], 0);
    repeat (200) @(negedge clk);
    check_int("tx_dropped_write_frames", frames_done, 3);

    // RX good frame
    rx_exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    status_check("rx_full_status", 8'h03);
    check8("rx_full_irq_n", {7'h00, irq_n}, 8'h00);
    read_data_check("rx_data_3c");
    check8("rx_read_irq_n", {7'h00, irq_n}, 8'h01);
    status_check("rx_after_read_status", 8'h02);

    // overrun
    rx_exp_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    status_check("overrun_status", 8'h07);
    read_data_check("overrun_keeps_first");
    status_check("overrun_after_read", 8'h06);
    bus_write(1'b1, 8'h00);
    status_check("overrun_cleared", 8'h02);
    check8("overrun_cleared_irq_n", {7'h00, irq_n}, 8'h01);

    // framing error with rx_full held
    rx_exp_q.push_back(8'h66);
    send_rx(8'h66, 1'b1);
    send_rx(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    status_check("frame_err_status", 8'h0B);
    read_data_check("frame_err_keeps_byte");
    status_check("frame_err_after_read", 8'h0A);
    check8("frame_err_irq_n", {7'h00, irq_n}, 8'h00);
    bus_write(1'b1, 8'hFF);
    status_check("frame_err_cleared", 8'h02);

    // short low glitch is a false start
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    check8("glitch_rx_idle", {6'h00, dbg_state[1:0]}, 8'h00);
    status_check("glitch_status", 8'h02);

    // DATA reads landing on byte completion, with back-to-back RX frames
    rx_exp_q.push_back(8'hC3);
    send_rx(8'hC3, 1'b1);
    repeat (4) @(negedge clk);
    status_check("coincide_pre_status", 8'h03);
    rx_exp_q.push_back(8'h96);
    rx_exp_q.push_back(8'h4B);
    fork
      begin
        send_rx(8'h96, 1'b1);
        send_rx(8'h4B, 1'b1);
      end
      begin
        repeat (154) @(negedge clk);
        read_data_check("coincide_read_1");
        repeat (159) @(negedge clk);
        read_data_check("coincide_read_2");
      end
    join
    repeat (4) @(negedge clk);
    status_check("coincide_status", 8'h03);
    read_data_check("coincide_last_byte");
    status_check("coincide_final_status", 8'h02);

    // reset in the middle of a TX frame, with a received byte pending
    send_rx(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    status_check("pre_reset_status", 8'h03);
    tx_exp_q.push_back(8'h00);
    bus_write(1'b0, 8'h00);
    repeat (50) @(negedge clk);
    check8("txd_mid_frame", {7'h00, txd}, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    check8("txd_async_reset", {7'h00, txd}, 8'h01);
    check8("irq_n_async_reset", {7'h00, irq_n}, 8'h01);
    check8("fsm_async_reset", {4'h0, dbg_state}, 8'h00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    status_check("post_reset_status", 8'h02);
    bus_read(1'b0, d);
    check8("post_reset_rx_data", d, 8'h00);
    repeat (200) @(negedge clk);
    check_int("post_reset_frames", frames_done, 3);
    check_int("tx_queue_drained", tx_exp_q.size(), 0);
    check_int("rx_queue_drained", rx_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
